stream_pack_fifo: RTL and testbench



---
 rtl/stream_pack_fifo.sv | 115 +++++++++++
 tb/tb_stream_pack_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/stream_pack_fifo.sv
// Packs PACK consecutive samples of a non-stallable stream into one word and buffers the words
// in a first-word-fall-through FIFO; words arriving while the FIFO is full are dropped and counted.
module stream_pack_fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PACK       = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH*PACK-1:0]   out_data,
  output logic [ADDR_WIDTH:0]          level,
  output logic                         overflow,
  output logic [15:0]                  drop_count
);

  localparam int unsigned CntWidth  = $clog2(PACK);
  localparam int unsigned WordWidth = DATA_WIDTH * PACK;
  localparam int unsigned PtrWidth  = ADDR_WIDTH + 1;

  logic [CntWidth-1:0]   cnt_q;
  logic [DATA_WIDTH-1:0] lane_q [PACK-1];
  logic [WordWidth-1:0]  mem_q [FIFO_DEPTH];
  logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
  logic                  overflow_q;
  logic [15:0]           drop_count_q;

  logic                  last_lane, push, pop, full, empty, push_ok, drop;
  logic [WordWidth-1:0]  push_word;

  always_comb begin
    last_lane = (cnt_q == CntWidth'(PACK - 1));
    push      = in_valid & ~flush & last_lane;
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    pop       = ~empty & out_ready;
    // A pop frees the slot on the same edge, so a full FIFO can still take the word.
    push_ok   = push & (~full | pop);
    drop      = push & full & ~pop;
  end

  // The final sample goes straight into the top lane without being registered.
  always_comb begin
    push_word = '0;
    for (int i = 0; i < PACK - 1; i++) begin
      push_word[i*DATA_WIDTH +: DATA_WIDTH] = lane_q[i];
    end
    push_word[WordWidth-1 -: DATA_WIDTH] = in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      for (int i = 0; i < PACK - 1; i++) begin
        lane_q[i] <= '0;
      end
    end else if (flush) begin
      cnt_q <= '0;
    end else if (in_valid) begin
      if (last_lane) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CntWidth'(1);
        for (int i = 0; i < PACK - 1; i++) begin
          if (cnt_q == CntWidth'(i)) begin
            lane_q[i] <= in_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= push_word;
        wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_count_q != 16'hFFFF) begin
        drop_count_q <= drop_count_q + 16'd1;
      end
    end
  end

  assign out_valid  = ~empty;
  assign out_data   = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign level      = wr_ptr_q - rd_ptr_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_stream_pack_fifo.sv
// Directed bench for stream_pack_fifo: packing, gaps, overflow, full-with-pop, flush, async reset.
module tb_stream_pack_fifo;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  level;
  logic        overflow;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  stream_pack_fifo #(
    .DATA_WIDTH(16),
    .PACK      (4),
    .FIFO_DEPTH(8),
    .ADDR_WIDTH(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drops", 64'(drop_count), 64'd0);
    chk("rst_data", out_data, 64'd0);
    rst = 1'b0;
    step();

    // Basic pack with consumer always ready
    out_ready = 1'b1;
    send(16'd1);
    send(16'd2);
    send(16'd3);
    chk("basic_no_early_valid", 64'(out_valid), 64'd0);
    send(16'd4);
    chk("basic_valid", 64'(out_valid), 64'd1);
    chk("basic_data", out_data, 64'h0004_0003_0002_0001);
    chk("basic_level", 64'(level), 64'd1);
    step();
    chk("basic_drained", 64'(level), 64'd0);
    chk("basic_valid_low", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Gapped input
    for (int i = 0; i < 4; i++) begin
      send(16'h10 + 16'(i));
      if (i < 3) begin
        repeat (3) step();
        chk("gap_no_spurious", 64'(out_valid), 64'd0);
      end
    end
    chk("gap_valid", 64'(out_valid), 64'd1);
    chk("gap_data", out_data, 64'h0013_0012_0011_0010);
    chk("gap_level", 64'(level), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("gap_drained", 64'(level), 64'd0);

    // Fill and overflow
    for (int i = 0; i < 32; i++) send(16'(i));
    chk("fill_level", 64'(level), 64'd8);
    chk("fill_no_ovf", 64'(overflow), 64'd0);
    for (int i = 32; i < 36; i++) send(16'(i));
    chk("ovf_level", 64'(level), 64'd8);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drops", 64'(drop_count), 64'd1);
    chk("ovf_head", out_data, 64'h0003_0002_0001_0000);

    // Full with a pop on the same edge as the push
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) send(16'd100 + 16'(i));
    chk("full2_level", 64'(level), 64'd8);
    for (int i = 32; i < 35; i++) send(16'd100 + 16'(i));
    out_ready = 1'b1;
    send(16'd135);
    out_ready = 1'b0;
    chk("fullpop_level", 64'(level), 64'd8);
    chk("fullpop_ovf", 64'(overflow), 64'd0);
    chk("fullpop_drops", 64'(drop_count), 64'd0);
    chk("fullpop_head", out_data, 64'h006B_006A_0069_0068);
    out_ready = 1'b1;
    repeat (7) step();
    out_ready = 1'b0;
    chk("fullpop_tail_level", 64'(level), 64'd1);
    chk("fullpop_tail_data", out_data, 64'h0087_0086_0085_0084);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("fullpop_empty", 64'(out_valid), 64'd0);

    // Flush discards the partial word and the sample presented with it
    send(16'h21);
    send(16'h22);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h99;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_no_word", 64'(out_valid), 64'd0);
    send(16'd5);
    send(16'd6);
    send(16'd7);
    send(16'd8);
    chk("flush_level", 64'(level), 64'd1);
    chk("flush_data", out_data, 64'h0008_0007_0006_0005);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Async reset mid-stream
    for (int i = 0; i < 14; i++) send(16'h40 + 16'(i));
    chk("arst_pre_level", 64'(level), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_level", 64'(level), 64'd0);
    chk("arst_data", out_data, 64'd0);
    #1;
    rst = 1'b0;
    step();
    send(16'd9);
    send(16'd10);
    send(16'd11);
    send(16'd12);
    chk("arst_post_level", 64'(level), 64'd1);
    chk("arst_post_data", out_data, 64'h000C_000B_000A_0009);
    chk("arst_post_drops", 64'(drop_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
